// File: rtl/divider_32bu.sv
// divider_32bu: 32-bit unsigned restoring divider.
// One quotient bit per clock, fixed 32-cycle latency.
module divider_32bu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        finish,
  output logic        busy,
  output logic        dz
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [5:0]  cnt;

  logic [32:0] sh;
  logic [32:0] sub;
  logic [31:0] nrem;
  logic [31:0] nquo;
  logic        ge;
  logic        last;
  logic        accept;

  // One restoring step: borrow out of the trial subtract picks the bit
  always_comb begin
    sh     = {rem, dvd[31]};
    sub    = sh - {1'b0, dvs};
    ge     = ~sub[32];
    nrem   = ge ? sub[31:0] : sh[31:0];
    nquo   = {quo[30:0], ge};
    last   = (cnt == 6'd31);
    accept = (state == IDLE) && start;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration and result publication
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      finish <= 1'b0;
      busy   <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      dvd    <= a;
      dvs    <= b;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      finish <= 1'b0;
      busy   <= 1'b1;
      dz     <= 1'b0;
    end else if (state == RUN) begin
      dvd <= {dvd[30:0], 1'b0};
      rem <= nrem;
      quo <= nquo;
      cnt <= cnt + 6'd1;
      if (last) begin
        q      <= nquo;
        r      <= nrem;
        finish <= 1'b1;
        busy   <= 1'b0;
        dz     <= (dvs == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_divider_32bu.sv
// tb_divider_32bu: random and directed checks of divider_32bu
// against an arithmetic reference model.
module tb_divider_32bu;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [31:0] q;
  logic [31:0] r;
  logic        finish;
  logic        busy;
  logic        dz;

  divider_32bu dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .q(q),
    .r(r),
    .finish(finish),
    .busy(busy),
    .dz(dz)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] m_q    = '0;
  logic [31:0] m_r    = '0;
  logic [31:0] pa     = '0;
  logic [31:0] pb     = '0;
  logic        m_fin  = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_dz   = 1'b0;
  int          m_left = 0;

  // Reference: a job takes 32 edges, result is plain / and %
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = '0; m_r = '0; m_fin = 0;
      m_busy = 0; m_dz = 0; m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_fin  = 1;
        m_dz   = (pb == 0);
        m_q    = (pb == 0) ? 32'hFFFF_FFFF : pa / pb;
        m_r    = (pb == 0) ? pa : pa % pb;
      end
    end else if (start) begin
      pa = a; pb = b;
      m_busy = 1; m_fin = 0; m_dz = 0;
      m_left = 32;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    n_tot++;
    if ({q, r, finish, busy, dz} === {m_q, m_r, m_fin, m_busy, m_dz})
      n_pass++;
    else
      $display("FAIL cycle t=%0t: dut q=%h r=%h f=%b bz=%b dz=%b, model q=%h r=%h f=%b bz=%b dz=%b",
               $time, q, r, finish, busy, dz, m_q, m_r, m_fin, m_busy, m_dz);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic run_div(input logic [31:0] aa, input logic [31:0] bb, input bit lit,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!finish && lat < 40) begin
      a = $urandom;
      b = $urandom;
      start = (lat < 31) ? ($urandom_range(0, 1) == 1) : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, 32);
    if (lit) begin
      chk("q", q, eq);
      chk("r", r, er);
      chk("dz", {31'b0, dz}, {31'b0, edz});
      chk("finish", {31'b0, finish}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_flags", {29'b0, finish, busy, dz}, 32'd0);

    // start high during reset must not be taken
    start = 1'b1; a = 32'd45; b = 32'd7;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_accept", {31'b0, busy}, 32'd1);
    wait_idle();
    chk("rst_start_q", q, 32'd6);
    chk("rst_start_r", r, 32'd3);

    run_div(32'd10, 32'd3, 1, 32'd3, 32'd1, 1'b0);
    run_div(32'd7, 32'd32, 1, 32'd0, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1, 32'd0, 1'b0);
    run_div(32'd123, 32'd0, 1, 32'hFFFF_FFFF, 32'd123, 1'b1);

    // Operand change and extra start mid-run, then abort by reset
    @(negedge clk);
    a = 32'd10; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd99; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_flags", {29'b0, finish, busy, dz}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0);

    // start held high: back-to-back jobs, one-cycle finish
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 110; i++) begin
      a = $urandom;
      b = $urandom_range(0, 20);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: begin ra = $urandom; rb = 32'd1; end
        1: begin ra = $urandom_range(0, 1000); rb = $urandom | 32'h8000_0000; end
        2: begin ra = 32'd0; rb = $urandom; end
        3: begin ra = $urandom; rb = 32'd0; end
        4: begin ra = $urandom; rb = $urandom_range(1, 255); end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      run_div(ra, rb, 0, 32'd0, 32'd0, 1'b0);
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/divider_32bu.md
DIVIDER_32BU -- requirements
Module: divider_32bu

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a division, sampled on rising clk.
REQ-005 a  input  32  unsigned dividend, sampled only on the cycle start is accepted.
REQ-006 b  input  32  unsigned divisor, sampled only on the cycle start is accepted.
REQ-007 q  output  32  unsigned quotient, registered.
REQ-008 r  output  32  unsigned remainder, registered.
REQ-009 finish  output  1  high while q/r hold a completed result.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 dz  output  1  high with finish when the accepted divisor was zero.

Function
REQ-012 SHALL use a two-state FSM: IDLE and RUN.
REQ-013 IDLE: start=1 on a rising edge SHALL accept the request.
- Acceptance latches a and b internally and clears the 6-bit iteration counter.
- Acceptance drives busy=1, finish=0 and dz=0, and enters RUN.
REQ-014 RUN SHALL perform one restoring-division step per cycle, MSB of dividend first.
- Step: partial remainder (33 bits) = (partial << 1) | next dividend bit.
- If partial >= divisor: subtract divisor and shift quotient bit 1; else shift quotient bit 0.
REQ-015 After exactly 32 steps (rising edges N+1..N+32 for acceptance at edge N), the block SHALL load q and r, set finish=1 and busy=0, and return to IDLE.
REQ-016 q and r SHALL satisfy a = q*b + r with r < b for every b != 0.
REQ-017 Divisor zero SHALL run the same 32-cycle sequence.
- Result: q=0xFFFFFFFF, r=a, dz=1.
REQ-018 q, r, finish and dz SHALL hold unchanged in IDLE until the next start is accepted; on acceptance finish and dz drop and q, r keep their old values until completion.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 Changes on a or b after acceptance SHALL NOT affect the running result.
REQ-021 start held high continuously SHALL begin a new division on the first edge in IDLE after completion.
- finish is therefore high for exactly one cycle before being cleared.
REQ-022 Latency from the accepting edge to finish=1 SHALL be 32 clocks, independent of operand values.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, q=0, r=0, finish=0, busy=0, dz=0, and clear all internal registers.
REQ-024 Reset asserted mid-division SHALL abort the operation with no partial result exposed.
REQ-025 A start sampled high while rst=0 SHALL be ignored; the first acceptance is on the first rising edge with rst=1.

Verification
REQ-026 a=10, b=3, start pulse -> after 32 clocks: finish=1, q=3, r=1, dz=0.
REQ-027 a=7, b=32 -> q=0, r=7.
REQ-028 a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
- Follow-up: a=0xFFFFFFFF, b=0xFFFFFFFF -> q=1, r=0.
REQ-029 a=123, b=0 -> q=0xFFFFFFFF, r=123, dz=1, latency 32.
REQ-030 Start 10/3, change a/b and pulse start at cycle 5, then assert rst at cycle 20:
- After the cycle-5 changes and start pulse, the result is still unaffected (q=3, r=1 if allowed to finish).
- When rst asserts at cycle 20, all outputs are 0 immediately.
- Next division after reset: 100/7 -> q=14, r=2.
REQ-031 Random regression (1000 pairs, including b=1, b>a, a=0) SHALL match a/b and a%b against a reference model.
